// File: rtl/rf_alu_pipe.sv
// rtl/rf_alu_pipe.sv - two-stage register-file/ALU datapath with forwarding and collision flag
module rf_alu_pipe #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_in_valid,
  input  logic [AW-1:0] i_rd_addr_a,
  input  logic [AW-1:0] i_rd_addr_b,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [1:0]    i_op,
  input  logic          i_init_we,
  input  logic [AW-1:0] i_init_addr,
  input  logic [DW-1:0] i_init_data,
  output logic          o_out_valid,
  output logic [AW-1:0] o_out_addr,
  output logic [DW-1:0] o_out_data,
  output logic          o_out_carry,
  output logic          o_busy,
  output logic [15:0]   o_op_count,
  output logic          o_err
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_XOR  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  // register file
  logic [DW-1:0] r_mem [DEPTH];

  // stage 1: captured operation and operands
  logic          r_s1_valid;
  op_e           r_s1_op;
  logic [AW-1:0] r_s1_waddr;
  logic [DW-1:0] r_s1_a;
  logic [DW-1:0] r_s1_b;

  // stage 2: registered completion
  logic          r_out_valid;
  logic [AW-1:0] r_out_addr;
  logic [DW-1:0] r_out_data;
  logic          r_out_carry;
  logic [15:0]   r_op_count;
  logic          r_err;

  logic [DW:0]   w_sum;
  logic [DW:0]   w_diff;
  logic [DW-1:0] w_alu_res;
  logic          w_alu_carry;
  logic [DW-1:0] w_rd_a;
  logic [DW-1:0] w_rd_b;
  logic          w_collision;

  // ALU evaluated on the stage-1 operands; borrow is the top bit of the widened difference
  always_comb begin
    w_sum       = {1'b0, r_s1_a} + {1'b0, r_s1_b};
    w_diff      = {1'b0, r_s1_a} - {1'b0, r_s1_b};
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    case (r_s1_op)
      OP_ADD: begin
        w_alu_res   = w_sum[DW-1:0];
        w_alu_carry = w_sum[DW];
      end
      OP_SUB: begin
        w_alu_res   = w_diff[DW-1:0];
        w_alu_carry = w_diff[DW];
      end
      OP_XOR:  w_alu_res = r_s1_a ^ r_s1_b;
      OP_PASS: w_alu_res = r_s1_a;
      default: w_alu_res = '0;
    endcase
  end

  // the stage-2 write beats an init load to the same address, so it must also win on forwarding
  assign w_collision = i_init_we && r_s1_valid && (i_init_addr == r_s1_waddr);

  // operand A read: in-flight result first, then same-edge init load, then the array
  always_comb begin
    w_rd_a = r_mem[i_rd_addr_a];
    if (r_s1_valid && (i_rd_addr_a == r_s1_waddr)) begin
      w_rd_a = w_alu_res;
    end else if (i_init_we && (i_init_addr == i_rd_addr_a)) begin
      w_rd_a = i_init_data;
    end
  end

  // operand B read, same priority as operand A
  always_comb begin
    w_rd_b = r_mem[i_rd_addr_b];
    if (r_s1_valid && (i_rd_addr_b == r_s1_waddr)) begin
      w_rd_b = w_alu_res;
    end else if (i_init_we && (i_init_addr == i_rd_addr_b)) begin
      w_rd_b = i_init_data;
    end
  end

  // array writes: init load unless it collides with the pipeline write-back
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_init_we && !w_collision) begin
        r_mem[i_init_addr] <= i_init_data;
      end
      if (r_s1_valid) begin
        r_mem[r_s1_waddr] <= w_alu_res;
      end
    end
  end

  // stage 1 capture of an issued operation
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_ADD;
      r_s1_waddr <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else begin
      r_s1_valid <= i_in_valid;
      if (i_in_valid) begin
        r_s1_op    <= op_e'(i_op);
        r_s1_waddr <= i_wr_addr;
        r_s1_a     <= w_rd_a;
        r_s1_b     <= w_rd_b;
      end
    end
  end

  // stage 2 completion: outputs hold between completions
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_out_carry <= 1'b0;
      r_op_count  <= '0;
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_addr  <= r_s1_waddr;
        r_out_data  <= w_alu_res;
        r_out_carry <= w_alu_carry;
        r_op_count  <= r_op_count + 16'd1;
      end
    end
  end

  // sticky collision flag, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (w_collision) begin
      r_err <= 1'b1;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_addr  = r_out_addr;
  assign o_out_data  = r_out_data;
  assign o_out_carry = r_out_carry;
  assign o_busy      = r_s1_valid | r_out_valid;
  assign o_op_count  = r_op_count;
  assign o_err       = r_err;

endmodule
